// File: rtl/cva6_wt_sbuf_pkg.sv
// Shared types and helpers for the write-through dcache store buffer.
package cva6_wt_sbuf_pkg;

    localparam int SBUF_DEPTH  = 8;
    localparam int SBUF_PLEN   = 56;
    localparam int SBUF_DATA_W = 64;
    localparam int SBUF_TID_W  = 2;

    // Life cycle of one buffer slot: FREE -> VALID -> ISSUED -> DONE -> FREE.
    typedef enum logic [1:0] {
        FREE   = 2'd0,
        VALID  = 2'd1,
        ISSUED = 2'd2,
        DONE   = 2'd3
    } sbuf_state_e;

    typedef struct packed {
        sbuf_state_e                 state;
        logic [SBUF_PLEN-4:0]        wpaddr;
        logic [SBUF_DATA_W-1:0]      data;
        logic [7:0]                  be;
        logic [SBUF_TID_W-1:0]       tid;
    } sbuf_entry_t;

    // 64-bit word address of a byte address.
    function automatic logic [SBUF_PLEN-4:0] word_addr(input logic [SBUF_PLEN-1:0] paddr);
        return paddr[SBUF_PLEN-1:3];
    endfunction

endpackage

// File: rtl/cva6_wt_sbuf_tid_pool.sv
// Transaction-ID pool: free bitmap, hands out the lowest free ID.
// A TID freed in one cycle becomes visible as free in the next cycle.
module cva6_wt_sbuf_tid_pool #(
    parameter int TID_W = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    alloc_i,
    input  logic [TID_W-1:0]        alloc_tid_i,
    input  logic                    free_i,
    input  logic [TID_W-1:0]        free_tid_i,
    output logic                    avail_o,
    output logic [TID_W-1:0]        lowest_o,
    output logic [(1<<TID_W)-1:0]   busy_o
);

    localparam int NTID = 1 << TID_W;

    logic [NTID-1:0] busy_q;
    logic [NTID-1:0] busy_d;

    assign busy_o = busy_q;

    // Next bitmap: allocation and release may hit different IDs in the same cycle.
    always_comb begin
        busy_d = busy_q;
        if (alloc_i) busy_d[alloc_tid_i] = 1'b1;
        if (free_i)  busy_d[free_tid_i]  = 1'b0;
    end

    // Lowest free ID from the registered bitmap (scan high to low, last hit wins).
    always_comb begin
        avail_o  = 1'b0;
        lowest_o = '0;
        for (int i = NTID - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                avail_o  = 1'b1;
                lowest_o = TID_W'(i);
            end
        end
    end

    // Bitmap register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) busy_q <= '0;
        else         busy_q <= busy_d;
    end

endmodule

// File: rtl/cva6_wt_store_buffer.sv
// Write buffer between committed stores and the write-through dcache memory port.
// Coalesces stores to the most recently allocated word, issues in order with TIDs,
// retires in order on out-of-order acks, and flags loads hitting a pending word.
//
// Handshakes: a store transfers when st_valid_i && st_ready_o in the same cycle;
// a memory write transfers when mem_req_o && mem_gnt_i. Once mem_req_o rises it
// stays high with a stable payload and TID until granted.
module cva6_wt_store_buffer
    import cva6_wt_sbuf_pkg::*;
#(
    parameter int DEPTH  = SBUF_DEPTH,
    parameter int PLEN   = SBUF_PLEN,
    parameter int DATA_W = SBUF_DATA_W,
    parameter int TID_W  = SBUF_TID_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              st_valid_i,
    output logic              st_ready_o,
    input  logic [PLEN-1:0]   st_paddr_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic [7:0]        st_be_i,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [PLEN-1:0]   mem_paddr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [7:0]        mem_be_o,
    output logic [TID_W-1:0]  mem_tid_o,
    input  logic              mem_ack_i,
    input  logic [TID_W-1:0]  mem_ack_tid_i,
    input  logic [PLEN-1:0]   ld_paddr_i,
    output logic              ld_hit_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int NTID  = 1 << TID_W;
    localparam logic [CNT_W-1:0] FULL_CNT = DEPTH[CNT_W-1:0];

    sbuf_entry_t      entries_q [DEPTH];
    sbuf_entry_t      entries_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, issue_q, issue_d, tail_q, tail_d, tail_m1;
    logic [CNT_W-1:0] count_q, count_d;
    logic             tid_hold_q;
    logic [TID_W-1:0] tid_hold_id_q;
    logic             tid_avail;
    logic [TID_W-1:0] tid_lowest;
    logic [NTID-1:0]  tid_busy;
    logic             accept, merge, alloc, grant, ack_ok, retire;
    sbuf_entry_t      issue_entry;

    assign tail_m1     = tail_q - PTR_W'(1);
    assign issue_entry = entries_q[issue_q];

    assign st_ready_o  = (count_q != FULL_CNT);
    assign empty_o     = (count_q == '0);
    assign accept      = st_valid_i && st_ready_o;

    // A held TID keeps the presented request stable even if a lower TID frees up.
    assign mem_req_o   = (issue_entry.state == VALID) && (tid_hold_q || tid_avail);
    assign mem_tid_o   = tid_hold_q ? tid_hold_id_q : tid_lowest;
    assign mem_paddr_o = {issue_entry.wpaddr, 3'b000};
    assign mem_data_o  = issue_entry.data;
    assign mem_be_o    = issue_entry.be;
    assign grant       = mem_req_o && mem_gnt_i;

    // Coalesce only into the newest entry, and never into one on the memory port.
    assign merge  = (entries_q[tail_m1].state == VALID)
                 && (entries_q[tail_m1].wpaddr == word_addr(st_paddr_i))
                 && !(mem_req_o && (issue_q == tail_m1));
    assign alloc  = accept && !merge;
    assign ack_ok = mem_ack_i && tid_busy[mem_ack_tid_i];
    assign retire = (entries_q[head_q].state == DONE);

    cva6_wt_sbuf_tid_pool #(.TID_W(TID_W)) i_tid_pool (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .alloc_i     (grant),
        .alloc_tid_i (mem_tid_o),
        .free_i      (ack_ok),
        .free_tid_i  (mem_ack_tid_i),
        .avail_o     (tid_avail),
        .lowest_o    (tid_lowest),
        .busy_o      (tid_busy)
    );

    // Load hazard: any occupied slot holding the load's word.
    always_comb begin
        ld_hit_o = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries_q[i].state != FREE && entries_q[i].wpaddr == word_addr(ld_paddr_i))
                ld_hit_o = 1'b1;
        end
    end

    // Next entry states and pointers; accept, grant, ack and retire touch disjoint slots.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        issue_d   = issue_q;
        tail_d    = tail_q;
        if (accept) begin
            if (merge) begin
                for (int b = 0; b < 8; b++) begin
                    if (st_be_i[b]) entries_d[tail_m1].data[8*b +: 8] = st_data_i[8*b +: 8];
                end
                entries_d[tail_m1].be = entries_q[tail_m1].be | st_be_i;
            end else begin
                entries_d[tail_q].state  = VALID;
                entries_d[tail_q].wpaddr = word_addr(st_paddr_i);
                entries_d[tail_q].data   = st_data_i;
                entries_d[tail_q].be     = st_be_i;
                entries_d[tail_q].tid    = '0;
                tail_d = tail_q + PTR_W'(1);
            end
        end
        if (grant) begin
            entries_d[issue_q].state = ISSUED;
            entries_d[issue_q].tid   = mem_tid_o;
            issue_d = issue_q + PTR_W'(1);
        end
        if (ack_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (entries_q[i].state == ISSUED && entries_q[i].tid == mem_ack_tid_i)
                    entries_d[i].state = DONE;
            end
        end
        if (retire) begin
            entries_d[head_q].state = FREE;
            head_d = head_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(alloc) - CNT_W'(retire);
    end

    // State registers; reset discards every entry and any held TID.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) entries_q[i] <= '0;
            head_q        <= '0;
            issue_q       <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            tid_hold_q    <= 1'b0;
            tid_hold_id_q <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            issue_q   <= issue_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            if (grant) begin
                tid_hold_q <= 1'b0;
            end else if (mem_req_o) begin
                tid_hold_q    <= 1'b1;
                tid_hold_id_q <= mem_tid_o;
            end
        end
    end

`ifndef SYNTHESIS
    // An ack naming an idle TID is a memory-side protocol error; it is dropped.
    ack_tid_busy_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_ack_i |-> tid_busy[mem_ack_tid_i])
        else $warning("store buffer: ack for idle tid %0d dropped", mem_ack_tid_i);
`endif

endmodule

// File: tb/tb_cva6_wt_store_buffer.sv
// Bench for cva6_wt_store_buffer: directed sequences, a load-hit vector table,
// and randomized traffic checked against a queue-based model.
module tb_cva6_wt_store_buffer;

    localparam int PLEN  = 56;
    localparam int DEPTH = 8;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        st_valid_i = 1'b0;
    logic        st_ready_o;
    logic [55:0] st_paddr_i = '0;
    logic [63:0] st_data_i = '0;
    logic [7:0]  st_be_i = '0;
    logic        mem_req_o;
    logic        mem_gnt_i = 1'b0;
    logic [55:0] mem_paddr_o;
    logic [63:0] mem_data_o;
    logic [7:0]  mem_be_o;
    logic [1:0]  mem_tid_o;
    logic        mem_ack_i = 1'b0;
    logic [1:0]  mem_ack_tid_i = '0;
    logic [55:0] ld_paddr_i = '0;
    logic        ld_hit_o;
    logic        empty_o;

    cva6_wt_store_buffer dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .st_valid_i    (st_valid_i),
        .st_ready_o    (st_ready_o),
        .st_paddr_i    (st_paddr_i),
        .st_data_i     (st_data_i),
        .st_be_i       (st_be_i),
        .mem_req_o     (mem_req_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_paddr_o   (mem_paddr_o),
        .mem_data_o    (mem_data_o),
        .mem_be_o      (mem_be_o),
        .mem_tid_o     (mem_tid_o),
        .mem_ack_i     (mem_ack_i),
        .mem_ack_tid_i (mem_ack_tid_i),
        .ld_paddr_i    (ld_paddr_i),
        .ld_hit_o      (ld_hit_o),
        .empty_o       (empty_o)
    );

    always #5 clk_i = ~clk_i;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        st_valid_i    = 1'b0;
        mem_gnt_i     = 1'b0;
        mem_ack_i     = 1'b0;
        mem_ack_tid_i = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_ni = 1'b0;
        cyc();
        cyc();
        rst_ni = 1'b1;
    endtask

    task automatic set_store(input logic [55:0] a, input logic [63:0] d, input logic [7:0] be);
        st_valid_i = 1'b1;
        st_paddr_i = a;
        st_data_i  = d;
        st_be_i    = be;
    endtask

    task automatic set_ack(input logic [1:0] t);
        mem_ack_i     = 1'b1;
        mem_ack_tid_i = t;
    endtask

    // Bounded wait for the buffer to drain.
    task automatic wait_empty(input string name, input int max_cycles);
        for (int k = 0; k <= max_cycles; k++) begin
            #1;
            if (empty_o) break;
            cyc();
        end
        chk1(name, empty_o, 1'b1);
    endtask

    function automatic logic [63:0] be_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{be[b]}};
        return m;
    endfunction

    typedef struct {
        logic [55:0] ld;
        logic        hit;
    } ld_vec_t;

    ld_vec_t ld_vecs[7];

    // Reference model: one record per occupied buffer slot, oldest first.
    typedef struct {
        logic [52:0] waddr;
        logic [63:0] data;
        logic [7:0]  be;
        bit          issued;
        bit          acked;
        int          tid;
    } rec_t;

    rec_t mq[$];
    bit   busy[4];
    bit   hold_v;
    int   hold_tid;
    int   bl[$];
    int   nu, lf, exp_tid, last;
    bit   exp_req, retire_now, exp_hit;
    rec_t r;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        ld_vecs[0] = '{56'h8000_0020, 1'b1};
        ld_vecs[1] = '{56'h8000_0024, 1'b1};
        ld_vecs[2] = '{56'h8000_0027, 1'b1};
        ld_vecs[3] = '{56'h8000_0028, 1'b0};
        ld_vecs[4] = '{56'h8000_001F, 1'b0};
        ld_vecs[5] = '{56'h1_8000_0020, 1'b0};
        ld_vecs[6] = '{56'h0000_0020, 1'b0};

        // Reset values.
        do_reset();
        #1;
        chk1("rst_ready", st_ready_o, 1'b1);
        chk1("rst_req", mem_req_o, 1'b0);
        chk1("rst_empty", empty_o, 1'b1);
        chk1("rst_ld_hit", ld_hit_o, 1'b0);
        cyc();

        // 1: single store, issue, ack, drain.
        set_store(56'h8000_0000, 64'h1122334455667788, 8'hFF);
        #1; chk1("t1_req_same_cycle", mem_req_o, 1'b0);
        cyc();
        st_valid_i = 1'b0;
        mem_gnt_i  = 1'b1;
        #1;
        chk1("t1_req", mem_req_o, 1'b1);
        chk("t1_tid", 64'(mem_tid_o), 64'd0);
        chk("t1_paddr", 64'(mem_paddr_o), 64'h8000_0000);
        chk("t1_data", mem_data_o, 64'h1122334455667788);
        chk("t1_be", 64'(mem_be_o), 64'hFF);
        cyc();
        mem_gnt_i = 1'b0;
        set_ack(2'd0);
        #1; chk1("t1_req_after_gnt", mem_req_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0;
        wait_empty("t1_empty", 2);

        // 2: exhaust TIDs, then two half-word stores coalesce into one write.
        do_reset();
        mem_gnt_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) set_store(56'h8000_0100 + 56'(i * 8), {$urandom, $urandom}, 8'hFF);
            else       st_valid_i = 1'b0;
            #1;
            if (i > 0) begin
                chk1($sformatf("t2_req%0d", i - 1), mem_req_o, 1'b1);
                chk($sformatf("t2_tid%0d", i - 1), 64'(mem_tid_o), 64'(i - 1));
            end
            cyc();
        end
        set_store(56'h8000_0010, 64'hAAAA_AAAA_1111_2222, 8'h0F);
        #1; chk1("t2_req_exhausted_a", mem_req_o, 1'b0);
        cyc();
        set_store(56'h8000_0014, 64'h3333_4444_BBBB_BBBB, 8'hF0);
        #1; chk1("t2_req_exhausted_b", mem_req_o, 1'b0);
        cyc();
        st_valid_i = 1'b0;
        mem_gnt_i  = 1'b0;
        set_ack(2'd0);
        #1; chk1("t2_req_exhausted_c", mem_req_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0;
        mem_gnt_i = 1'b1;
        #1;
        chk1("t2_merged_req", mem_req_o, 1'b1);
        chk("t2_merged_tid", 64'(mem_tid_o), 64'd0);
        chk("t2_merged_paddr", 64'(mem_paddr_o), 64'h8000_0010);
        chk("t2_merged_be", 64'(mem_be_o), 64'hFF);
        chk("t2_merged_data", mem_data_o, 64'h3333_4444_1111_2222);
        cyc();
        mem_gnt_i = 1'b0;
        set_ack(2'd1);
        #1; cyc();
        mem_ack_i = 1'b0;
        #1; chk1("t2_single_entry", mem_req_o, 1'b0);
        cyc();

        // 3: fill to DEPTH, then free the head and watch ready return.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_store(56'h8000_0200 + 56'(i * 8), {$urandom, $urandom}, 8'h01);
            #1; chk1($sformatf("t3_ready%0d", i), st_ready_o, 1'b1);
            cyc();
        end
        st_valid_i = 1'b0;
        mem_gnt_i  = 1'b1;
        #1;
        chk1("t3_full", st_ready_o, 1'b0);
        chk1("t3_req_head", mem_req_o, 1'b1);
        cyc();
        mem_gnt_i = 1'b0;
        set_ack(2'd0);
        #1; chk1("t3_full_ack", st_ready_o, 1'b0);
        cyc();
        mem_ack_i = 1'b0;
        #1; chk1("t3_full_retire", st_ready_o, 1'b0);
        cyc();
        #1; chk1("t3_ready_back", st_ready_o, 1'b1);
        cyc();

        // 4: out-of-order acks retire in order.
        do_reset();
        mem_gnt_i  = 1'b1;
        ld_paddr_i = 56'h8000_0308;
        set_store(56'h8000_0300, {$urandom, $urandom}, 8'hFF);
        #1; cyc();
        set_store(56'h8000_0308, {$urandom, $urandom}, 8'hFF);
        #1; chk("t4_tid0", 64'(mem_tid_o), 64'd0);
        cyc();
        st_valid_i = 1'b0;
        #1; chk("t4_tid1", 64'(mem_tid_o), 64'd1);
        cyc();
        mem_gnt_i = 1'b0;
        set_ack(2'd1);
        #1; cyc();
        mem_ack_i = 1'b0;
        #1; chk1("t4_not_empty_a", empty_o, 1'b0);
        cyc();
        set_ack(2'd0);
        #1;
        chk1("t4_head_blocked", empty_o, 1'b0);
        chk1("t4_done_entry_hit", ld_hit_o, 1'b1);
        cyc();
        mem_ack_i = 1'b0;
        #1; chk1("t4_retire_first", empty_o, 1'b0);
        cyc();
        #1; chk1("t4_retire_second", empty_o, 1'b0);
        cyc();
        #1; chk1("t4_empty", empty_o, 1'b1);
        cyc();

        // 5: load-hit vector table against a pending store.
        do_reset();
        set_store(56'h8000_0020, {$urandom, $urandom}, 8'h0F);
        #1; cyc();
        st_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            ld_paddr_i = ld_vecs[i].ld;
            #1; chk1($sformatf("t5_ld_hit_%0d", i), ld_hit_o, ld_vecs[i].hit);
            cyc();
        end

        // 6: reset with issued entries; stale and idle acks are dropped.
        do_reset();
        mem_gnt_i  = 1'b1;
        ld_paddr_i = 56'h8000_0400;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) set_store(56'h8000_0400 + 56'(i * 8), {$urandom, $urandom}, 8'hFF);
            else       st_valid_i = 1'b0;
            #1; cyc();
        end
        mem_gnt_i = 1'b0;
        rst_ni    = 1'b0;
        #1; cyc();
        rst_ni = 1'b1;
        #1;
        chk1("t6_empty", empty_o, 1'b1);
        chk1("t6_req", mem_req_o, 1'b0);
        chk1("t6_ready", st_ready_o, 1'b1);
        chk1("t6_ld_hit", ld_hit_o, 1'b0);
        set_ack(2'd0);
        cyc();
        mem_ack_i = 1'b0;
        #1; chk1("t6_stale_ack_empty", empty_o, 1'b1);
        set_store(56'h8000_0400, {$urandom, $urandom}, 8'hFF);
        cyc();
        st_valid_i = 1'b0;
        mem_gnt_i  = 1'b1;
        #1;
        chk1("t6_new_req", mem_req_o, 1'b1);
        chk("t6_new_tid", 64'(mem_tid_o), 64'd0);
        cyc();
        mem_gnt_i = 1'b0;
        set_ack(2'd1);
        cyc();
        mem_ack_i = 1'b0;
        cyc();
        cyc();
        #1; chk1("t6_idle_ack_ignored", empty_o, 1'b0);
        set_ack(2'd0);
        cyc();
        mem_ack_i = 1'b0;
        wait_empty("t6_drain", 2);

        // Randomized traffic against the queue model.
        do_reset();
        mq.delete();
        for (int t = 0; t < 4; t++) busy[t] = 1'b0;
        hold_v = 1'b0;
        hold_tid = 0;
        for (int c = 0; c < 600; c++) begin
            st_valid_i = ($urandom_range(0, 2) != 0);
            st_paddr_i = 56'h8000_0000 + 56'($urandom_range(0, 31));
            st_data_i  = {$urandom, $urandom};
            st_be_i    = 8'($urandom_range(1, 255));
            mem_gnt_i  = ($urandom_range(0, 1) == 1);
            ld_paddr_i = 56'h8000_0000 + 56'($urandom_range(0, 47));
            bl.delete();
            for (int t = 0; t < 4; t++) if (busy[t]) bl.push_back(t);
            if (bl.size() > 0 && $urandom_range(0, 2) == 0) begin
                mem_ack_i     = 1'b1;
                mem_ack_tid_i = 2'(bl[$urandom_range(0, bl.size() - 1)]);
            end else begin
                mem_ack_i = 1'b0;
            end
            #1;
            nu = -1;
            for (int i = 0; i < mq.size(); i++) if (!mq[i].issued && nu < 0) nu = i;
            lf = -1;
            for (int t = 3; t >= 0; t--) if (!busy[t]) lf = t;
            exp_req = (nu >= 0) && (hold_v || lf >= 0);
            exp_tid = hold_v ? hold_tid : lf;
            exp_hit = 1'b0;
            for (int i = 0; i < mq.size(); i++) if (mq[i].waddr == ld_paddr_i[55:3]) exp_hit = 1'b1;
            chk1("rnd_req", mem_req_o, exp_req);
            chk1("rnd_ready", st_ready_o, mq.size() < DEPTH);
            chk1("rnd_empty", empty_o, mq.size() == 0);
            chk1("rnd_ld_hit", ld_hit_o, exp_hit);
            if (exp_req && mem_req_o) begin
                chk("rnd_tid", 64'(mem_tid_o), 64'(exp_tid));
                chk("rnd_paddr", 64'(mem_paddr_o), 64'({mq[nu].waddr, 3'b000}));
                chk("rnd_be", 64'(mem_be_o), 64'(mq[nu].be));
                chk("rnd_data", mem_data_o & be_mask(mq[nu].be), mq[nu].data & be_mask(mq[nu].be));
            end
            // Advance the model by this cycle's events.
            retire_now = (mq.size() > 0) && mq[0].acked;
            if (mem_ack_i) begin
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].issued && !mq[i].acked && mq[i].tid == int'(mem_ack_tid_i)) mq[i].acked = 1'b1;
                busy[mem_ack_tid_i] = 1'b0;
            end
            if (exp_req && mem_gnt_i) begin
                mq[nu].issued = 1'b1;
                mq[nu].tid    = exp_tid;
                busy[exp_tid] = 1'b1;
                hold_v        = 1'b0;
            end else if (exp_req) begin
                hold_v   = 1'b1;
                hold_tid = exp_tid;
            end
            if (st_valid_i && mq.size() < DEPTH) begin
                last = mq.size() - 1;
                if (last >= 0 && !mq[last].issued && mq[last].waddr == st_paddr_i[55:3]
                    && !(exp_req && nu == last)) begin
                    for (int b = 0; b < 8; b++)
                        if (st_be_i[b]) mq[last].data[8*b +: 8] = st_data_i[8*b +: 8];
                    mq[last].be = mq[last].be | st_be_i;
                end else begin
                    r.waddr  = st_paddr_i[55:3];
                    r.data   = st_data_i;
                    r.be     = st_be_i;
                    r.issued = 1'b0;
                    r.acked  = 1'b0;
                    r.tid    = 0;
                    mq.push_back(r);
                end
            end
            if (retire_now) void'(mq.pop_front());
            cyc();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
